ad7606_seq_ctrl: RTL and testbench
==================================

// Module: ad7606_seq_ctrl
// PURPOSE
// Parametrised AD7606-family sequencer: timed CONVST, BUSY wait, parallel RD/CS read of NUM_CH channels.
// Successor to the fixed 8-ch controller. Adds:
//   - configurable channel count and data width
//   - oversampling select and a periodic sample trigger
//   - BUSY timeout and overrun detection
// Sits between the ADC pins and downstream capture/FIFO logic.
// PARAMETERS
// NUM_CH      8    channels read per frame (1..8)
// DATA_W      16   ADC data bus width
// SAMPLE_DIV  5000 clk cycles between conversion triggers (>= 2)
// CONV_LOW    2    clk cycles CONVST held low
// RD_LOW      3    clk cycles RD_N low per channel
// RD_HIGH     2    clk cycles RD_N high between channels
// RST_CYC     10   clk cycles ad_reset held high after rst release
// BUSY_TO     2000 max clk cycles waiting on either BUSY edge
// PORTS
// clk         in   1       system clock
// rst         in   1       asynchronous reset, active-high
// enable      in   1       1 = periodic conversions run
// os_ratio    in   3       oversampling code 0..6 (7 treated as 6)
// ad_busy     in   1       ADC BUSY (asynchronous; 2-flop synchronised)
// ad_data     in   DATA_W  ADC parallel data
// ad_convst   out  1       CONVST (A/B tied), idle high
// ad_cs_n     out  1       chip select, active-low
// ad_rd_n     out  1       read strobe, active-low
// ad_reset    out  1       ADC reset pulse
// ad_os       out  3       OS pins
// ch_valid    out  1       1-cycle strobe: ch_data/ch_idx valid
// ch_idx      out  3       channel index of ch_data (0..NUM_CH-1)
// ch_data     out  DATA_W  captured sample
// frame_done  out  1       1-cycle pulse after last channel read
// timeout_err out  1       1-cycle pulse on BUSY timeout
// overrun     out  1       1-cycle pulse: trigger arrived while not IDLE
// BEHAVIOUR
// Reset values:
//   - ad_convst=1, ad_cs_n=1, ad_rd_n=1, ad_reset=0, ad_os=0
//   - all strobes 0, ch_idx=0, ch_data=0, state=ST_ARST
// FSM states: ST_ARST, IDLE, CONV, WAIT_HI, WAIT_LO, RD_LO, RD_HI, DONE.
// ST_ARST:
//   - ad_reset=1 for RST_CYC cycles, then IDLE
//   - entered only via rst; rst mid-frame aborts immediately, no strobes emitted
// Trigger counter:
//   - free-runs 0..SAMPLE_DIV-1 while enable=1; held at 0 when enable=0
//   - tick at count SAMPLE_DIV-1
// IDLE:
//   - ad_os <= min(os_ratio,6) every cycle (OS changes apply from next frame only)
//   - on tick -> CONV
// CONV: ad_convst=0 for CONV_LOW cycles, then 1 -> WAIT_HI.
// WAIT_HI / WAIT_LO:
//   - wait for synced busy=1, then synced busy=0
//   - shared timeout counter reset on entry to each state
//   - BUSY_TO cycles elapsed -> timeout_err pulse, cs/rd idle, back to IDLE, no frame_done
// RD phase:
//   - ad_cs_n=0 from first RD_LO entry until DONE
//   - RD_LO drives ad_rd_n=0 for RD_LOW cycles; ad_data is registered on the final RD_LO cycle
//   - ch_valid=1 the following cycle, with ch_idx = current channel
//   - RD_HI drives ad_rd_n=1 for RD_HIGH cycles
//   - channel counter increments; after channel NUM_CH-1 -> DONE
// DONE: ad_cs_n=1, frame_done=1 for one cycle -> IDLE.
// Overrun:
//   - tick while state != IDLE -> overrun pulse, tick discarded, current frame unaffected
// enable dropped mid-frame: the frame completes; no new trigger is issued.
// Latency: tick -> first ch_valid = 1 + CONV_LOW + busy-high + busy-low + 2 sync + RD_LOW + 1 cycles.
// TESTING
// 1. rst 1->0 -> ad_reset high exactly RST_CYC cycles; convst/cs/rd stay 1.
// 2. Normal frame:
//    - stimulus: NUM_CH=8; BUSY model high 5 cycles after CONVST rise, then low; ad_data = 16'h1000 + idx
//    - response: 8 ch_valid with ch_data 0x1000..0x1007, ch_idx 0..7; one frame_done; cs_n low only during reads
// 3. BUSY stuck 0 after CONVST -> timeout_err after BUSY_TO cycles; no ch_valid; next tick starts a fresh frame.
// 4. SAMPLE_DIV shorter than frame time -> overrun pulse at each mid-frame tick; frames still complete with correct data.
// 5. Mid-frame changes:
//    - os_ratio=3 -> ad_os=3 only from next IDLE; os_ratio=7 -> ad_os=6
//    - rst asserted during RD_LO of ch 4 -> outputs return to reset values asynchronously; no frame_done
// 6. NUM_CH=1, DATA_W=14 -> single ch_valid per frame, ch_idx=0, 14-bit data intact.

Source files
------------

// File: rtl/ad7606_seq_ctrl.sv
// AD7606-family conversion sequencer: periodic CONVST, synchronised BUSY wait with timeout,
// then an RD/CS parallel read of NUM_CH channels streamed out as ch_valid strobes.
`timescale 1ns/1ps
module ad7606_seq_ctrl #(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SAMPLE_DIV = 5000,
  parameter int unsigned CONV_LOW   = 2,
  parameter int unsigned RD_LOW     = 3,
  parameter int unsigned RD_HIGH    = 2,
  parameter int unsigned RST_CYC    = 10,
  parameter int unsigned BUSY_TO    = 2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [2:0]        os_ratio,
  input  logic              ad_busy,
  input  logic [DATA_W-1:0] ad_data,
  output logic              ad_convst,
  output logic              ad_cs_n,
  output logic              ad_rd_n,
  output logic              ad_reset,
  output logic [2:0]        ad_os,
  output logic              ch_valid,
  output logic [2:0]        ch_idx,
  output logic [DATA_W-1:0] ch_data,
  output logic              frame_done,
  output logic              timeout_err,
  output logic              overrun
);

  localparam int unsigned M1      = (RST_CYC > BUSY_TO) ? RST_CYC : BUSY_TO;
  localparam int unsigned M2      = (CONV_LOW > RD_LOW) ? CONV_LOW : RD_LOW;
  localparam int unsigned M3      = (M2 > RD_HIGH) ? M2 : RD_HIGH;
  localparam int unsigned TMR_MAX = (M1 > M3) ? M1 : M3;
  localparam int unsigned TW      = $clog2(TMR_MAX + 1);
  localparam int unsigned CW      = $clog2(SAMPLE_DIV);

  typedef enum logic [2:0] {
    StArst, StIdle, StConv, StWaitHi, StWaitLo, StRdLo, StRdHi, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [2:0]        ch_q, ch_d;
  logic [CW-1:0]     div_q;
  logic              tick;
  logic              busy_s1_q, busy_s2_q;
  logic              capture, to_pulse;

  logic              convst_q, cs_n_q, rd_n_q, ad_reset_q;
  logic [2:0]        os_q;
  logic              valid_q, done_q, to_q, ovr_q;
  logic [2:0]        idx_q;
  logic [DATA_W-1:0] data_q;

  // Trigger divider only runs while enabled so re-enabling always waits a full period.
  assign tick = enable && (div_q == CW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else if (!enable || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_s1_q <= 1'b0;
      busy_s2_q <= 1'b0;
    end else begin
      busy_s1_q <= ad_busy;
      busy_s2_q <= busy_s1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StArst;
      tmr_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ch_q    <= ch_d;
    end
  end

  // tmr is shared by every timed state and cleared on each state entry.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q + TW'(1);
    ch_d     = ch_q;
    capture  = 1'b0;
    to_pulse = 1'b0;
    case (state_q)
      StArst: begin
        if (tmr_q == TW'(RST_CYC)) begin
          state_d = StIdle;
          tmr_d   = '0;
        end
      end
      StIdle: begin
        tmr_d = '0;
        ch_d  = '0;
        if (tick) state_d = StConv;
      end
      StConv: begin
        if (tmr_q == TW'(CONV_LOW - 1)) begin
          state_d = StWaitHi;
          tmr_d   = '0;
        end
      end
      StWaitHi: begin
        if (busy_s2_q) begin
          state_d = StWaitLo;
          tmr_d   = '0;
        end else if (tmr_q == TW'(BUSY_TO - 1)) begin
          state_d  = StIdle;
          to_pulse = 1'b1;
        end
      end
      StWaitLo: begin
        if (!busy_s2_q) begin
          state_d = StRdLo;
          tmr_d   = '0;
        end else if (tmr_q == TW'(BUSY_TO - 1)) begin
          state_d  = StIdle;
          to_pulse = 1'b1;
        end
      end
      StRdLo: begin
        if (tmr_q == TW'(RD_LOW - 1)) begin
          state_d = StRdHi;
          tmr_d   = '0;
          capture = 1'b1;
        end
      end
      StRdHi: begin
        if (tmr_q == TW'(RD_HIGH - 1)) begin
          tmr_d = '0;
          if (ch_q == 3'(NUM_CH - 1)) begin
            state_d = StDone;
          end else begin
            state_d = StRdLo;
            ch_d    = ch_q + 3'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        tmr_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Pins are registered from the next state so they change cleanly with the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      convst_q   <= 1'b1;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      ad_reset_q <= 1'b0;
      os_q       <= '0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      to_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      convst_q   <= (state_d != StConv);
      cs_n_q     <= !((state_d == StRdLo) || (state_d == StRdHi));
      rd_n_q     <= (state_d != StRdLo);
      ad_reset_q <= (state_d == StArst);
      if (state_q == StIdle) os_q <= (os_ratio == 3'd7) ? 3'd6 : os_ratio;
      valid_q    <= capture;
      if (capture) begin
        idx_q  <= ch_q;
        data_q <= ad_data;
      end
      done_q     <= (state_d == StDone);
      to_q       <= to_pulse;
      ovr_q      <= tick && (state_q != StIdle);
    end
  end

  assign ad_convst   = convst_q;
  assign ad_cs_n     = cs_n_q;
  assign ad_rd_n     = rd_n_q;
  assign ad_reset    = ad_reset_q;
  assign ad_os       = os_q;
  assign ch_valid    = valid_q;
  assign ch_idx      = idx_q;
  assign ch_data     = data_q;
  assign frame_done  = done_q;
  assign timeout_err = to_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_ad7606_seq_ctrl.sv
// Bench for ad7606_seq_ctrl: three configurations, each with an ADC pin model and a
// frame-level scoreboard (expected sample list per frame) checked every cycle.
`timescale 1ns/1ps
module tb_ad7606_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  en = 3'b000;
  logic [2:0]  os_ratio = 3'd0;
  logic [2:0]  busy = 3'b000;
  logic [15:0] adc_data [3];

  wire  [2:0]  convst, cs_n, rd_n, ares, vld, fdone, to_err, ovr;
  wire  [2:0]  os0, os1, os2, idx0, idx1, idx2;
  wire  [15:0] dat0, dat2;
  wire  [13:0] dat1;

  int n_chk = 0, n_err = 0;
  int exp_idx [3], n_vld [3], n_done [3], n_to [3], n_ov [3], cs_lo [3], last_cs_lo [3];
  int bcnt [3], rd_cnt [3];
  bit cv_prev [3], rd_prev [3], stuck [3];
  logic [15:0] base [3], last_dat [3];
  int num_ch [3];

  always #5 clk = ~clk;

  ad7606_seq_ctrl #(.NUM_CH(8), .DATA_W(16), .SAMPLE_DIV(200), .CONV_LOW(2), .RD_LOW(3),
                    .RD_HIGH(2), .RST_CYC(10), .BUSY_TO(40)) dut (
    .clk(clk), .rst(rst), .enable(en[0]), .os_ratio(os_ratio), .ad_busy(busy[0]),
    .ad_data(adc_data[0]), .ad_convst(convst[0]), .ad_cs_n(cs_n[0]), .ad_rd_n(rd_n[0]),
    .ad_reset(ares[0]), .ad_os(os0), .ch_valid(vld[0]), .ch_idx(idx0), .ch_data(dat0),
    .frame_done(fdone[0]), .timeout_err(to_err[0]), .overrun(ovr[0]));

  ad7606_seq_ctrl #(.NUM_CH(1), .DATA_W(14), .SAMPLE_DIV(50), .CONV_LOW(2), .RD_LOW(3),
                    .RD_HIGH(2), .RST_CYC(10), .BUSY_TO(40)) dut1 (
    .clk(clk), .rst(rst), .enable(en[1]), .os_ratio(os_ratio), .ad_busy(busy[1]),
    .ad_data(adc_data[1][13:0]), .ad_convst(convst[1]), .ad_cs_n(cs_n[1]), .ad_rd_n(rd_n[1]),
    .ad_reset(ares[1]), .ad_os(os1), .ch_valid(vld[1]), .ch_idx(idx1), .ch_data(dat1),
    .frame_done(fdone[1]), .timeout_err(to_err[1]), .overrun(ovr[1]));

  ad7606_seq_ctrl #(.NUM_CH(8), .DATA_W(16), .SAMPLE_DIV(30), .CONV_LOW(2), .RD_LOW(3),
                    .RD_HIGH(2), .RST_CYC(10), .BUSY_TO(40)) dut_ov (
    .clk(clk), .rst(rst), .enable(en[2]), .os_ratio(os_ratio), .ad_busy(busy[2]),
    .ad_data(adc_data[2]), .ad_convst(convst[2]), .ad_cs_n(cs_n[2]), .ad_rd_n(rd_n[2]),
    .ad_reset(ares[2]), .ad_os(os2), .ch_valid(vld[2]), .ch_idx(idx2), .ch_data(dat2),
    .frame_done(fdone[2]), .timeout_err(to_err[2]), .overrun(ovr[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ADC model + scoreboard, evaluated on the falling edge where DUT outputs are stable.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [15:0] d, e;
      logic [2:0]  ix;
      d  = (i == 0) ? dat0 : (i == 1) ? {2'b00, dat1} : dat2;
      ix = (i == 0) ? idx0 : (i == 1) ? idx1 : idx2;
      // BUSY high for 5 cycles from the CONVST rising edge unless held stuck low.
      if (!cv_prev[i] && convst[i] && !stuck[i]) begin
        busy[i] = 1'b1;
        bcnt[i] = 4;
      end else if (bcnt[i] > 0) begin
        bcnt[i]--;
      end else begin
        busy[i] = 1'b0;
      end
      cv_prev[i] = convst[i];
      // Each RD falling edge within a CS window presents the next channel's word.
      if (cs_n[i]) begin
        rd_cnt[i] = 0;
      end else if (rd_prev[i] && !rd_n[i]) begin
        adc_data[i] = base[i] + 16'(rd_cnt[i]);
        rd_cnt[i]++;
      end
      rd_prev[i] = rd_n[i];

      if (rst) begin
        exp_idx[i] = 0;
        cs_lo[i]   = 0;
      end else begin
        if (!cs_n[i]) cs_lo[i]++;
        if (!rd_n[i] || !convst[i])
          check("pin exclusion", {29'd0, convst[i], cs_n[i], rd_n[i]},
                !rd_n[i] ? 32'b100 : 32'b011);
        if (vld[i]) begin
          e = base[i] + 16'(exp_idx[i]);
          if (i == 1) e = {2'b00, e[13:0]};
          check("ch_idx", {29'd0, ix}, 32'(exp_idx[i]));
          check("ch_data", {16'd0, d}, {16'd0, e});
          last_dat[i] = d;
          exp_idx[i]++;
          n_vld[i]++;
        end
        if (fdone[i]) begin
          check("channels per frame", 32'(exp_idx[i]), 32'(num_ch[i]));
          check("cs_n low cycles per frame", 32'(cs_lo[i]), 32'(num_ch[i] * 5));
          last_cs_lo[i] = cs_lo[i];
          exp_idx[i] = 0;
          cs_lo[i]   = 0;
          n_done[i]++;
        end
        if (to_err[i]) n_to[i]++;
        if (ovr[i]) n_ov[i]++;
      end
    end
  end

  task automatic tick_n();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int i, input int target, input int budget, input string name);
    int c = 0;
    while (n_done[i] < target && c < budget) begin
      tick_n();
      c++;
    end
    check(name, 32'(n_done[i]), 32'(target));
  endtask

  task automatic wait_convst_fall(input int i, input int budget);
    int c = 0;
    while (convst[i] && c < budget) begin
      tick_n();
      c++;
    end
    check("convst falls", {31'd0, convst[i]}, 32'd0);
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, " convst/cs/rd"}, {29'd0, convst[0], cs_n[0], rd_n[0]}, 32'b111);
    check({tag, " ad_reset"}, {31'd0, ares[0]}, 32'd0);
    check({tag, " strobes"}, {29'd0, vld[0], fdone[0], to_err[0]}, 32'd0);
    check({tag, " overrun"}, {31'd0, ovr[0]}, 32'd0);
    check({tag, " ch_idx"}, {29'd0, idx0}, 32'd0);
    check({tag, " ch_data"}, {16'd0, dat0}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    int c, hi;
    bit bad;
    num_ch = '{8, 1, 8};
    base   = '{16'h1000, 16'h3ABC, 16'h2000};
    for (int i = 0; i < 3; i++) begin
      adc_data[i] = 16'h0;
      stuck[i]    = 1'b0;
    end

    // Reset values and the ADC reset pulse after release.
    repeat (3) tick_n();
    check_reset_pins("reset");
    check("reset ad_os", {29'd0, os0}, 32'd0);
    rst = 1'b0;
    hi  = 0;
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick_n();
      if (ares[0]) hi++;
      if (!convst[0] || !cs_n[0] || !rd_n[0]) bad = 1'b1;
    end
    check("ad_reset high cycles", 32'(hi), 32'd10);
    check("pins idle during ADC reset", {31'd0, bad}, 32'd0);

    // Normal frame, first-sample latency, OS pins deferred to the next idle period.
    en[0] = 1'b1;
    wait_convst_fall(0, 250);
    c = 0;
    while (!vld[0] && c < 100) begin
      tick_n();
      c++;
    end
    check("first ch_valid latency", 32'(c), 32'd13);
    os_ratio = 3'd3;
    tick_n();
    check("ad_os held mid-frame", {29'd0, os0}, 32'd0);
    wait_done(0, 1, 200, "frame 1 done");
    check("frame 1 samples", 32'(n_vld[0]), 32'd8);
    check("frame 1 last sample", {16'd0, last_dat[0]}, 32'h1007);
    check("frame 1 cs_n low span", 32'(last_cs_lo[0]), 32'd40);
    repeat (2) tick_n();
    check("ad_os after frame", {29'd0, os0}, 32'd3);
    os_ratio = 3'd7;
    repeat (2) tick_n();
    check("ad_os clamps 7 to 6", {29'd0, os0}, 32'd6);
    os_ratio = 3'd0;

    // BUSY never rises: timeout, no samples, then a clean frame on the next trigger.
    stuck[0] = 1'b1;
    wait_convst_fall(0, 250);
    c = 0;
    while (!to_err[0] && c < 100) begin
      tick_n();
      c++;
    end
    check("busy timeout latency", 32'(c), 32'd42);
    tick_n();
    check("timeout pulse count", 32'(n_to[0]), 32'd1);
    check("no samples on timeout", 32'(n_vld[0]), 32'd8);
    check("no frame_done on timeout", 32'(n_done[0]), 32'd1);
    stuck[0] = 1'b0;
    wait_done(0, 2, 300, "frame after timeout");
    check("frame after timeout samples", 32'(n_vld[0]), 32'd16);

    // Asynchronous reset while reading channel 4.
    c = 0;
    while (!(exp_idx[0] == 4 && !rd_n[0]) && c < 400) begin
      tick_n();
      c++;
    end
    check("reached ch 4 read", {31'd0, rd_n[0]}, 32'd0);
    rst = 1'b1;
    #1;
    check_reset_pins("mid-frame reset");
    repeat (3) tick_n();
    check("no frame_done after abort", 32'(n_done[0]), 32'd2);
    rst = 1'b0;
    wait_done(0, 3, 300, "frame after abort");
    check("samples after abort", 32'(n_vld[0]), 32'd28);

    // Enable dropped mid-frame: frame finishes, nothing new starts.
    wait_convst_fall(0, 250);
    en[0] = 1'b0;
    wait_done(0, 4, 200, "frame with enable dropped");
    check("samples with enable dropped", 32'(n_vld[0]), 32'd36);
    hi = 0;
    for (int k = 0; k < 250; k++) begin
      tick_n();
      if (!convst[0]) hi++;
    end
    check("no conversion while disabled", 32'(hi), 32'd0);

    // Single channel, 14-bit bus.
    en[1] = 1'b1;
    wait_done(1, 2, 200, "1ch frames done");
    en[1] = 1'b0;
    check("1ch samples", 32'(n_vld[1]), 32'd2);
    check("1ch data intact", {16'd0, last_dat[1]}, 32'h3ABC);

    // Trigger period shorter than a frame.
    en[2] = 1'b1;
    wait_done(2, 3, 400, "overrun frames done");
    en[2] = 1'b0;
    check("overrun pulses", 32'(n_ov[2]), 32'd3);
    check("overrun frames samples", 32'(n_vld[2]), 32'd24);
    check("overrun frames no timeout", 32'(n_to[2]), 32'd0);
    check("main never overran", 32'(n_ov[0]), 32'd0);
    check("1ch never overran", 32'(n_ov[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
